regfile_mp_sb: RTL and testbench

//  Parametrised multi-port general-purpose register file for the pipelined CPU, with per-register

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_sb_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp_sb.sv | 65 ++++++
 tb/tb_regfile_mp_sb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with pending-write scoreboard.
package regfile_pkg;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int DEPTH_DEF = 1 << AW_DEF;
  localparam int REG_ZERO  = 0;

  // Low bit of lane idx inside a flattened vector of w-bit lanes.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Operand-read / write-back / issue bundle between the ID-stage regfile and the pipeline.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
);
  localparam int DEPTH = 1 << AW;

  // No valid/ready handshake: each enable (we0, we1, iss) is a one-cycle strobe sampled on
  // posedge clk; the regfile always accepts it, and reads are combinational every cycle.
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              iss;
  logic [AW-1:0]     iss_a;
  logic [DEPTH-1:0]  busy;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, iss, iss_a,
    input  rd, rd_busy, busy
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, iss, iss_a,
    output rd, rd_busy, busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus per-read-port hazard lookup.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read address masks the hazard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss,
  input  logic [AW-1:0]      iss_a,
  input  logic               we0,
  input  logic [AW-1:0]      wa0,
  input  logic               we1,
  input  logic [AW-1:0]      wa1,
  input  logic [NRD*AW-1:0]  ra,
  output logic [(1<<AW)-1:0] busy,
  output logic [NRD-1:0]     rd_busy
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_n;

  // Clears are applied first so that a same-cycle issue re-marks the register busy.
  always_comb begin
    busy_n = busy_q;
    if (we0) busy_n[wa0] = 1'b0;
    if (we1) busy_n[wa1] = 1'b0;
    if (iss) busy_n[iss_a] = 1'b1;
    busy_n[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_n;
  end

  assign busy = busy_q;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0] a;
    assign a = ra[slice_lo(g, AW) +: AW];
    always_comb begin
      rd_busy[g] = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      if ((we0 && wa0 == a) || (we1 && wa1 == a)) rd_busy[g] = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file (NRD reads, 2 writes) with scoreboard; r0 hard-wired to zero.
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding (wd0 over wd1).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input logic             clk,
  input logic             rst_n,
  regfile_mp_sb_if.slave  bus
);
  localparam int            DEPTH  = 1 << AW;
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [DW-1:0]     mem [DEPTH];
  logic [NRD*DW-1:0] rd_v;
  logic [NRD-1:0]    rd_busy_v;
  logic [DEPTH-1:0]  busy_v;

  // Port 0 is assigned last: on an address collision the younger producer's data survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      if (bus.we1 && bus.wa1 != ZERO_A) mem[bus.wa1] <= bus.wd1;
      if (bus.we0 && bus.wa0 != ZERO_A) mem[bus.wa0] <= bus.wd0;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] val;
    assign a = bus.ra[slice_lo(g, AW) +: AW];
    always_comb begin
      val = mem[a];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so rd reads as zero while rst_n is low.
      if (rst_n && bus.we0 && bus.wa0 == a)      val = bus.wd0;
      else if (rst_n && bus.we1 && bus.wa1 == a) val = bus.wd1;
`endif
      if (a == ZERO_A) val = '0;
    end
    assign rd_v[slice_lo(g, DW) +: DW] = val;
  end

  regfile_scoreboard #(.AW(AW), .NRD(NRD)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .iss     (bus.iss),
    .iss_a   (bus.iss_a),
    .we0     (bus.we0),
    .wa0     (bus.wa0),
    .we1     (bus.we1),
    .wa1     (bus.wa1),
    .ra      (bus.ra),
    .busy    (busy_v),
    .rd_busy (rd_busy_v)
  );

  assign bus.rd      = rd_v;
  assign bus.rd_busy = rd_busy_v;
  assign bus.busy    = busy_v;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized self-checking bench for regfile_mp_sb (NRD=4) against an array-based model;
// honours REGFILE_BYPASS_EN for the forwarding expectations.
module tb_regfile_mp_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  regfile_mp_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  regfile_mp_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] model_reg [DEPTH];
  bit            model_busy [DEPTH];
  logic [DW-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (bypass_on() && bus.we0 && int'(bus.wa0) == a) return bus.wd0;
    if (bypass_on() && bus.we1 && int'(bus.wa1) == a) return bus.wd1;
    return model_reg[a];
  endfunction

  function automatic bit exp_rd_busy(input int a);
    bit fwd;
    fwd = bypass_on() && ((bus.we0 && int'(bus.wa0) == a) || (bus.we1 && int'(bus.wa1) == a));
    return model_busy[a] && !fwd;
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy_vec();
    logic [DEPTH-1:0] v;
    for (int r = 0; r < DEPTH; r++) v[r] = model_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      model_reg[r]  = '0;
      model_busy[r] = 1'b0;
    end
  endtask

  // Applied just after a posedge while the inputs for that edge are still held.
  task automatic model_update();
    if (bus.we1 && bus.wa1 != 0) model_reg[bus.wa1] = bus.wd1;
    if (bus.we0 && bus.wa0 != 0) model_reg[bus.wa0] = bus.wd0;
    if (bus.we0) model_busy[bus.wa0] = 1'b0;
    if (bus.we1) model_busy[bus.wa1] = 1'b0;
    if (bus.iss && bus.iss_a != 0) model_busy[bus.iss_a] = 1'b1;
  endtask

  task automatic check_all();
    int a;
    for (int i = 0; i < NRD; i++) begin
      a = int'(bus.ra[i*AW +: AW]);
      exp_q.push_back(exp_rd(a));
    end
    for (int i = 0; i < NRD; i++) begin
      a = int'(bus.ra[i*AW +: AW]);
      check("rd", bus.rd[i*DW +: DW], exp_q.pop_front());
      check("rd_busy", bus.rd_busy[i], exp_rd_busy(a));
    end
    check("busy", bus.busy, exp_busy_vec());
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.ra = '0; bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0; bus.iss = 0; bus.iss_a = '0;
  endtask

  task automatic set_ra(input int port, input int a);
    bus.ra[port*AW +: AW] = AW'(a);
  endtask

  // Inputs are set at negedge; outputs checked 1 ns later; model follows the posedge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    #0 model_update();
    @(negedge clk);
  endtask

  task automatic drive_random();
    int lim;
    lim = ($urandom_range(0, 1) == 1) ? 7 : DEPTH - 1;
    for (int i = 0; i < NRD; i++) set_ra(i, $urandom_range(0, lim));
    bus.we0   = ($urandom_range(0, 3) == 0);
    bus.wa0   = AW'($urandom_range(0, lim));
    bus.wd0   = DW'($urandom);
    bus.we1   = ($urandom_range(0, 2) == 0);
    bus.wa1   = AW'($urandom_range(0, lim));
    bus.wd1   = DW'($urandom);
    bus.iss   = ($urandom_range(0, 2) == 0);
    bus.iss_a = AW'($urandom_range(0, lim));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rd", bus.rd, '0);
    check("reset_busy", bus.busy, '0);
    check("reset_rd_busy", bus.rd_busy, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill r1..r31 with their index, mark a few busy, then reset mid-cycle.
    for (int r = 1; r < DEPTH; r++) begin
      idle();
      bus.we0 = 1; bus.wa0 = AW'(r); bus.wd0 = DW'(r);
      bus.iss = 1; bus.iss_a = AW'((r % 6) + 20);
      step();
    end
    idle();
    for (int i = 0; i < NRD; i++) set_ra(i, i + 1);
    step();
    check("prefill_r3", bus.rd[2*DW +: DW], 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rd", bus.rd, '0);
    check("midreset_busy", bus.busy, '0);
    check("midreset_rd_busy", bus.rd_busy, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Register 0 ignores writes and issues.
    idle();
    bus.we1 = 1; bus.wa1 = '0; bus.wd1 = 32'hDEAD_BEEF;
    bus.iss = 1; bus.iss_a = '0;
    step();
    idle();
    #1;
    check("r0_read", bus.rd[0 +: DW], '0);
    check("r0_busy", bus.busy[0], 1'b0);

    // Dual write collision: port 0 data survives.
    idle();
    bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'h11;
    bus.we1 = 1; bus.wa1 = 5; bus.wd1 = 32'h22;
    step();
    idle();
    set_ra(0, 5);
    #1;
    check("collision_r5", bus.rd[0 +: DW], 32'h11);

    // Scoreboard set / clear / same-cycle set-wins.
    idle();
    bus.iss = 1; bus.iss_a = 7;
    step();
    idle();
    #1 check("sb_set_c1", bus.busy[7], 1'b1);
    step();
    step();
    bus.we1 = 1; bus.wa1 = 7; bus.wd1 = 32'h77;
    step();
    idle();
    #1 check("sb_clr_c4", bus.busy[7], 1'b0);
    bus.iss = 1; bus.iss_a = 7;
    bus.we1 = 1; bus.wa1 = 7; bus.wd1 = 32'h78;
    step();
    idle();
    #1 check("sb_set_wins", bus.busy[7], 1'b1);

    // Forwarding behaviour on r9 with a pending producer.
    bus.we1 = 1; bus.wa1 = 9; bus.wd1 = 32'h1234;
    bus.iss = 1; bus.iss_a = 9;
    step();
    idle();
    set_ra(0, 9);
    bus.we0 = 1; bus.wa0 = 9; bus.wd0 = 32'hA5A5;
    #1;
    if (bypass_on()) begin
      check("fwd_rd0", bus.rd[0 +: DW], 32'hA5A5);
      check("fwd_rd_busy0", bus.rd_busy[0], 1'b0);
    end else begin
      check("nofwd_rd0", bus.rd[0 +: DW], 32'h1234);
      check("nofwd_rd_busy0", bus.rd_busy[0], 1'b1);
    end
    step();
    idle();
    set_ra(0, 9);
    #1;
    check("fwd_next_rd0", bus.rd[0 +: DW], 32'hA5A5);
    check("fwd_next_busy9", bus.busy[9], 1'b0);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      drive_random();
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
